// File: rtl/apb_demux_pkg.sv
// Shared types and constants for the APB fan-out stage with downstream timeout.
package apb_demux_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam int unsigned MAX_DATA_WIDTH = 1024;

    // Read data returned on decode errors and timeouts; cast down to the bus width at use.
    localparam logic [MAX_DATA_WIDTH-1:0] ERR_RDATA = '0;

    // Slave index width, never zero so a single-slave build still has a legal vector.
    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // Wait counter width able to hold TIMEOUT_CYCLES; one bit when the timeout is disabled.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_demux_timeout_if.sv
// APB bus bundle; NSEL selects wide (1 upstream, NB_SLAVES downstream) with per-select responses.
interface apb_demux_timeout_if #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned NSEL = 1
);
    logic [NSEL-1:0]         psel;
    logic                    penable;
    logic                    pwrite;
    logic [AW-1:0]           paddr;
    logic [DW-1:0]           pwdata;
    logic [NSEL-1:0][DW-1:0] prdata;
    logic [NSEL-1:0]         pready;
    logic [NSEL-1:0]         pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational region decoder: inclusive unsigned range match, lowest index wins.
module apb_addr_decode
    import apb_demux_pkg::*;
#(
    parameter int unsigned NB_SLAVES  = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    localparam int unsigned IDX_W     = idx_width(NB_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0]                 addr,
    input  logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0]  start_addr,
    input  logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0]  end_addr,
    output logic                                  hit_c,
    output logic [IDX_W-1:0]                      idx_c,
    output logic [NB_SLAVES-1:0]                  sel_c
);

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        sel_c = '0;
        for (int i = int'(NB_SLAVES) - 1; i >= 0; i--) begin
            if ((addr >= start_addr[i]) && (addr <= end_addr[i])) begin
                hit_c    = 1'b1;
                idx_c    = IDX_W'(i);
                sel_c    = '0;
                sel_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_demux_timeout.sv
// Registered APB 1-to-N demux; unmapped addresses and stalled slaves are answered with PSLVERR.
module apb_demux_timeout
    import apb_demux_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned NB_SLAVES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NB_SLAVES-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
    apb_demux_timeout_if.slave                       s_apb,
    apb_demux_timeout_if.master                      m_apb
);

    localparam int unsigned IDX_W = idx_width(NB_SLAVES);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    state_t                    state;
    logic [IDX_W-1:0]          idx_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [NB_SLAVES-1:0]      m_psel_q;
    logic                      m_penable_q;
    logic                      m_pwrite_q;
    logic [APB_ADDR_WIDTH-1:0] m_paddr_q;
    logic [APB_DATA_WIDTH-1:0] m_pwdata_q;

    logic                      s_pready_q;
    logic                      s_pslverr_q;
    logic [APB_DATA_WIDTH-1:0] s_prdata_q;

    logic                      dec_hit_c;
    logic [IDX_W-1:0]          dec_idx_c;
    logic [NB_SLAVES-1:0]      dec_sel_c;
    logic                      capture_c;
    logic                      timeout_c;

    apb_addr_decode #(
        .NB_SLAVES  (NB_SLAVES),
        .ADDR_WIDTH (APB_ADDR_WIDTH)
    ) u_decode (
        .addr       (s_apb.paddr),
        .start_addr (start_addr_i),
        .end_addr   (end_addr_i),
        .hit_c      (dec_hit_c),
        .idx_c      (dec_idx_c),
        .sel_c      (dec_sel_c)
    );

    assign capture_c = s_apb.psel[0] & ~s_apb.penable;
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Transfer FSM; every bus output is a register updated on the transition into its state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            s_pready_q  <= 1'b0;
            s_pslverr_q <= 1'b0;
            s_prdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture_c) begin
                        m_paddr_q  <= s_apb.paddr;
                        m_pwrite_q <= s_apb.pwrite;
                        m_pwdata_q <= s_apb.pwdata;
                        if (dec_hit_c) begin
                            idx_q    <= dec_idx_c;
                            m_psel_q <= dec_sel_c;
                            cnt_q    <= '0;
                            state    <= SETUP;
                        end else begin
                            s_pready_q  <= 1'b1;
                            s_pslverr_q <= 1'b1;
                            s_prdata_q  <= APB_DATA_WIDTH'(ERR_RDATA);
                            state       <= ERR;
                        end
                    end
                end

                SETUP: begin
                    m_penable_q <= 1'b1;
                    state       <= ACCESS;
                end

                // A response in the final timeout cycle still wins over the abort.
                ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (m_apb.pready[idx_q]) begin
                        s_prdata_q  <= m_apb.prdata[idx_q];
                        s_pslverr_q <= m_apb.pslverr[idx_q];
                        s_pready_q  <= 1'b1;
                        m_psel_q    <= '0;
                        m_penable_q <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_c) begin
                        s_prdata_q  <= APB_DATA_WIDTH'(ERR_RDATA);
                        s_pslverr_q <= 1'b1;
                        s_pready_q  <= 1'b1;
                        m_psel_q    <= '0;
                        m_penable_q <= 1'b0;
                        state       <= RESP;
                    end
                end

                RESP, ERR: begin
                    s_pready_q  <= 1'b0;
                    s_pslverr_q <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    m_psel_q    <= '0;
                    m_penable_q <= 1'b0;
                    s_pready_q  <= 1'b0;
                    s_pslverr_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign m_apb.psel    = m_psel_q;
    assign m_apb.penable = m_penable_q;
    assign m_apb.pwrite  = m_pwrite_q;
    assign m_apb.paddr   = m_paddr_q;
    assign m_apb.pwdata  = m_pwdata_q;

    assign s_apb.pready[0]  = s_pready_q;
    assign s_apb.pslverr[0] = s_pslverr_q;
    assign s_apb.prdata[0]  = s_prdata_q;

endmodule

// File: tb/tb_apb_demux_timeout.sv
// Directed bench for apb_demux_timeout: upstream APB master tasks and a per-slave wait-state model.
module tb_apb_demux_timeout;
    import apb_demux_pkg::*;

    logic clk;
    logic rst_n;
    logic [3:0][31:0] start_addr;
    logic [3:0][31:0] end_addr;

    int          wait_cfg [4];
    logic [31:0] slv_data [4];
    logic        slv_err  [4];
    int          acc_cnt  [4];

    int passed;
    int total;

    apb_demux_timeout_if #(.AW(32), .DW(32), .NSEL(1)) up_if ();
    apb_demux_timeout_if #(.AW(32), .DW(32), .NSEL(4)) dn_if ();

    apb_demux_timeout #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .NB_SLAVES      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_addr_i (start_addr),
        .end_addr_i   (end_addr),
        .s_apb        (up_if),
        .m_apb        (dn_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: ready after wait_cfg[i] extra ACCESS cycles (255 = never).
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dn_if.psel[i] && dn_if.penable) acc_cnt[i] <= acc_cnt[i] + 1;
            else                                acc_cnt[i] <= 0;
        end
    end

    always_comb begin
        dn_if.pready  = '0;
        dn_if.pslverr = '0;
        dn_if.prdata  = '0;
        for (int i = 0; i < 4; i++) begin
            dn_if.pready[i]  = dn_if.psel[i] & dn_if.penable & (acc_cnt[i] == wait_cfg[i]);
            dn_if.pslverr[i] = slv_err[i];
            dn_if.prdata[i]  = slv_data[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One upstream transfer; samples the downstream bus in the SETUP cycle and at the response.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int waits,
                        output int acc, output logic [3:0] t1_sel, output logic t1_pen,
                        output logic [31:0] t1_addr, output logic [31:0] t1_wdata,
                        output logic t1_wr, output logic [3:0] resp_sel);
        up_if.psel    = 1'b1;
        up_if.penable = 1'b0;
        up_if.pwrite  = wr;
        up_if.paddr   = addr;
        up_if.pwdata  = wdata;
        tick();
        up_if.penable = 1'b1;
        t1_sel   = dn_if.psel;
        t1_pen   = dn_if.penable;
        t1_addr  = dn_if.paddr;
        t1_wdata = dn_if.pwdata;
        t1_wr    = dn_if.pwrite;
        waits    = 0;
        acc      = 0;
        while (up_if.pready[0] !== 1'b1 && waits < 100) begin
            if (dn_if.penable === 1'b1) acc++;
            waits++;
            tick();
        end
        rdata    = up_if.prdata[0];
        err      = up_if.pslverr[0];
        resp_sel = dn_if.psel;
        tick();
        up_if.psel    = 1'b0;
        up_if.penable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (up_if.pready[0] !== 1'b0) $display("FAIL rst_pready: got %b want 0", up_if.pready[0]); else passed++;
        total++; if (up_if.pslverr[0] !== 1'b0) $display("FAIL rst_pslverr: got %b want 0", up_if.pslverr[0]); else passed++;
        total++; if (up_if.prdata[0] !== 32'h0) $display("FAIL rst_prdata: got %h want 0", up_if.prdata[0]); else passed++;
        total++; if (dn_if.psel !== 4'b0000 || dn_if.penable !== 1'b0 || dn_if.pwrite !== 1'b0)
            $display("FAIL rst_mctl: got psel=%b pen=%b pwr=%b want 0", dn_if.psel, dn_if.penable, dn_if.pwrite);
        else passed++;
        total++; if (dn_if.paddr !== 32'h0 || dn_if.pwdata !== 32'h0)
            $display("FAIL rst_mdata: got addr=%h wdata=%h want 0", dn_if.paddr, dn_if.pwdata);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_zero_wait();
        logic [31:0] rd, a, wd; logic er, pen, wr; int w, ac; logic [3:0] s1, sr;
        wait_cfg[1] = 0;
        xfer(1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (s1 !== 4'b0010 || pen !== 1'b0) $display("FAIL wr_setup: got psel=%b pen=%b want 0010/0", s1, pen); else passed++;
        total++; if (a !== 32'h1A10_0004 || wd !== 32'hDEAD_BEEF || wr !== 1'b1)
            $display("FAIL wr_payload: got addr=%h wdata=%h wr=%b want 1a100004/deadbeef/1", a, wd, wr);
        else passed++;
        total++; if (w !== 2) $display("FAIL wr_waits: got %0d want 2", w); else passed++;
        total++; if (er !== 1'b0) $display("FAIL wr_slverr: got %b want 0", er); else passed++;
        total++; if (ac !== 1 || sr !== 4'b0000) $display("FAIL wr_access: got acc=%0d resp_sel=%b want 1/0000", ac, sr); else passed++;
    endtask

    task automatic test_read_waits();
        logic [31:0] rd, a, wd; logic er, pen, wr; int w, ac; logic [3:0] s1, sr;
        wait_cfg[2] = 3;
        slv_data[2] = 32'h1234_5678;
        xfer(1'b0, 32'h1A10_2000, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (rd !== 32'h1234_5678) $display("FAIL rd_data: got %h want 12345678", rd); else passed++;
        total++; if (w !== 5) $display("FAIL rd_waits: got %0d want 5", w); else passed++;
        total++; if (s1 !== 4'b0100 || wr !== 1'b0 || ac !== 4)
            $display("FAIL rd_shape: got psel=%b wr=%b acc=%0d want 0100/0/4", s1, wr, ac);
        else passed++;
        total++; if (er !== 1'b0) $display("FAIL rd_slverr: got %b want 0", er); else passed++;
        slv_err[2] = 1'b1;
        wait_cfg[2] = 0;
        xfer(1'b0, 32'h1A10_2FFC, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (er !== 1'b1 || rd !== 32'h1234_5678) $display("FAIL rd_passerr: got err=%b data=%h want 1/12345678", er, rd); else passed++;
        slv_err[2] = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, a, wd; logic er, pen, wr; int w, ac; logic [3:0] s1, sr;
        xfer(1'b0, 32'h0000_0000, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (w !== 0) $display("FAIL unm_waits: got %0d want 0", w); else passed++;
        total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL unm_resp: got err=%b data=%h want 1/0", er, rd); else passed++;
        total++; if (s1 !== 4'b0000 || ac !== 0) $display("FAIL unm_quiet: got psel=%b acc=%0d want 0000/0", s1, ac); else passed++;
    endtask

    task automatic test_timeout();
        logic [31:0] rd, a, wd; logic er, pen, wr; int w, ac; logic [3:0] s1, sr;
        wait_cfg[0] = 255;
        slv_data[0] = 32'hAAAA_5555;
        xfer(1'b0, 32'h1A00_8000, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (ac !== 16 || w !== 17) $display("FAIL to_len: got acc=%0d waits=%0d want 16/17", ac, w); else passed++;
        total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL to_resp: got err=%b data=%h want 1/0", er, rd); else passed++;
        total++; if (s1 !== 4'b0001 || sr !== 4'b0000) $display("FAIL to_sel: got t1=%b resp=%b want 0001/0000", s1, sr); else passed++;
        wait_cfg[1] = 1;
        slv_data[1] = 32'h0BAD_F00D;
        xfer(1'b0, 32'h1A10_0800, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (rd !== 32'h0BAD_F00D || er !== 1'b0 || w !== 3)
            $display("FAIL to_after: got data=%h err=%b waits=%0d want 0badf00d/0/3", rd, er, w);
        else passed++;
        wait_cfg[0] = 15;
        xfer(1'b0, 32'h1A00_8000, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (er !== 1'b0 || rd !== 32'hAAAA_5555 || ac !== 16)
            $display("FAIL to_ready_wins: got err=%b data=%h acc=%0d want 0/aaaa5555/16", er, rd, ac);
        else passed++;
    endtask

    task automatic test_overlap();
        logic [31:0] rd, a, wd; logic er, pen, wr; int w, ac; logic [3:0] s1, sr;
        wait_cfg[0] = 0;
        wait_cfg[3] = 0;
        slv_data[3] = 32'h3333_3333;
        xfer(1'b0, 32'h1A00_0010, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (s1 !== 4'b0001) $display("FAIL ovl_sel: got %b want 0001", s1); else passed++;
        total++; if (rd !== 32'hAAAA_5555 || w !== 2) $display("FAIL ovl_resp: got data=%h waits=%0d want aaaa5555/2", rd, w); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, a, wd; logic er, pen, wr; int w, ac; logic [3:0] s1, sr;
        wait_cfg[1] = 0;
        xfer(1'b1, 32'hFFFF_0000, 32'h1, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        xfer(1'b1, 32'h1A10_0FFF, 32'hCAFE_0001, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (w !== 2 || er !== 1'b0 || s1 !== 4'b0010 || wd !== 32'hCAFE_0001)
            $display("FAIL b2b_hit: got waits=%0d err=%b psel=%b wdata=%h want 2/0/0010/cafe0001", w, er, s1, wd);
        else passed++;
        xfer(1'b0, 32'h1A10_1000, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (w !== 0 || er !== 1'b1) $display("FAIL b2b_gap: got waits=%0d err=%b want 0/1", w, er); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, a, wd; logic er, pen, wr; int w, ac; logic [3:0] s1, sr;
        wait_cfg[0] = 255;
        up_if.psel    = 1'b1;
        up_if.penable = 1'b0;
        up_if.pwrite  = 1'b0;
        up_if.paddr   = 32'h1A00_4000;
        tick();
        up_if.penable = 1'b1;
        tick();
        tick();
        total++; if (dn_if.psel !== 4'b0001 || dn_if.penable !== 1'b1)
            $display("FAIL rm_access: got psel=%b pen=%b want 0001/1", dn_if.psel, dn_if.penable);
        else passed++;
        rst_n = 1'b0;
        tick();
        total++; if (dn_if.psel !== 4'b0000 || dn_if.penable !== 1'b0 || up_if.pready[0] !== 1'b0)
            $display("FAIL rm_outputs: got psel=%b pen=%b pready=%b want 0/0/0", dn_if.psel, dn_if.penable, up_if.pready[0]);
        else passed++;
        total++; if (dut.state !== IDLE || dn_if.paddr !== 32'h0) $display("FAIL rm_state: got state=%0d addr=%h want 0/0", dut.state, dn_if.paddr); else passed++;
        rst_n = 1'b1;
        up_if.psel    = 1'b0;
        up_if.penable = 1'b0;
        tick();
        wait_cfg[1] = 0;
        xfer(1'b0, 32'h1A10_0010, 32'h0, rd, er, w, ac, s1, pen, a, wd, wr, sr);
        total++; if (rd !== 32'h0BAD_F00D || er !== 1'b0 || w !== 2)
            $display("FAIL rm_after: got data=%h err=%b waits=%0d want 0badf00d/0/2", rd, er, w);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        up_if.psel    = 1'b0;
        up_if.penable = 1'b0;
        up_if.pwrite  = 1'b0;
        up_if.paddr   = '0;
        up_if.pwdata  = '0;
        start_addr[0] = 32'h1A00_0000; end_addr[0] = 32'h1A00_FFFF;
        start_addr[1] = 32'h1A10_0000; end_addr[1] = 32'h1A10_0FFF;
        start_addr[2] = 32'h1A10_2000; end_addr[2] = 32'h1A10_2FFF;
        start_addr[3] = 32'h1A00_0000; end_addr[3] = 32'h1A00_0FFF;
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = 0;
            slv_data[i] = 32'h0;
            slv_err[i]  = 1'b0;
        end

        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_unmapped();
        test_timeout();
        test_overlap();
        test_back_to_back();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
